// File: rtl/traffic_light_fsm_pkg.sv
// ============================================================================
// Module   : traffic_light_fsm_pkg
// Purpose  : State codes, lamp codes and small helpers shared by the
//            intersection controller, its timer top and the benches.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package traffic_light_fsm_pkg;

    // Controller state encoding
    typedef logic [2:0] state_t;

    localparam state_t HW_GREEN  = 3'd0;
    localparam state_t HW_YELLOW = 3'd1;
    localparam state_t CR_GREEN  = 3'd2;
    localparam state_t CR_YELLOW = 3'd3;
    localparam state_t ST_FAULT  = 3'd4;

    // Lamp drive codes
    typedef logic [1:0] lamp_t;

    localparam lamp_t L_RED = 2'b00;
    localparam lamp_t L_YEL = 2'b01;
    localparam lamp_t L_GRN = 2'b10;

    // States whose dwell time is guarded by the watchdog
    function automatic logic is_bounded(input state_t s);
        return (s == HW_YELLOW) || (s == CR_GREEN) || (s == CR_YELLOW);
    endfunction

endpackage

`default_nettype wire

// File: rtl/traffic_light_fsm_sensor_sync.sv
// ============================================================================
// Module   : sensor_sync
// Purpose  : Two-flop synchroniser for the asynchronous road sensor, with an
//            asynchronous active-high clear.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sensor_sync (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two-stage capture of the asynchronous level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/traffic_light_fsm.sv
// ============================================================================
// Module   : traffic_light_fsm
// Purpose  : Highway / country-road intersection controller. Restarts the
//            external timer on every state entry, sequences the lamps on the
//            synchronised car sensor and timer expiries, and falls into a
//            flashing-yellow fault state if the timer stops reporting.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module traffic_light_fsm
    import traffic_light_fsm_pkg::*;
#(
    parameter int WDOG_CYCLES = 64,
    parameter int WDOG_W      = 7,
    parameter int BLINK_HALF  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       CAR,
    input  logic       T_HOLD,
    input  logic       T_YELLOW,
    output logic       START_TIMER,
    output logic [1:0] HW_LIGHT,
    output logic [1:0] CR_LIGHT,
    output logic       FAULT
);

    // BLINK_HALF must be at least 2 so the blink counter has a non-zero width
    localparam int                BLINK_W    = $clog2(BLINK_HALF);
    localparam logic [WDOG_W-1:0] WDOG_LAST  = WDOG_W'(WDOG_CYCLES - 1);
    localparam logic [WDOG_W-1:0] WDOG_SAT   = '1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);

    state_t             state_q, state_d;
    logic               arm_q;
    logic               start_q, start_d;
    lamp_t              hw_q, hw_d;
    lamp_t              cr_q, cr_d;
    logic               fault_q, fault_d;
    logic [WDOG_W-1:0]  wdog_q, wdog_d;
    logic [BLINK_W-1:0] blink_q, blink_d;
    logic               blink_on_q, blink_on_d;

    logic car_s;
    logic hold_ok;
    logic yel_ok;
    logic wdog_expired;
    logic entering;

    sensor_sync u_car_sync (
        .clk (clk),
        .rst (rst),
        .d_i (CAR),
        .q_o (car_s)
    );

    // The timer needs a cycle to restart, so expiries seen alongside our own
    // START pulse still belong to the previous interval and are discarded.
    assign hold_ok      = T_HOLD   && !start_q;
    assign yel_ok       = T_YELLOW && !start_q;
    assign wdog_expired = (wdog_q == WDOG_LAST);

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= HW_GREEN;
            arm_q      <= 1'b1;
            start_q    <= 1'b0;
            hw_q       <= L_GRN;
            cr_q       <= L_RED;
            fault_q    <= 1'b0;
            wdog_q     <= '0;
            blink_q    <= '0;
            blink_on_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            arm_q      <= 1'b0;
            start_q    <= start_d;
            hw_q       <= hw_d;
            cr_q       <= cr_d;
            fault_q    <= fault_d;
            wdog_q     <= wdog_d;
            blink_q    <= blink_d;
            blink_on_q <= blink_on_d;
        end
    end

    // Next-state selection; a real transition always wins over watchdog expiry
    always_comb begin
        state_d = state_q;
        if (!arm_q) begin
            case (state_q)
                HW_GREEN: begin
                    if (car_s && hold_ok) state_d = HW_YELLOW;
                end
                HW_YELLOW: begin
                    if (yel_ok)            state_d = CR_GREEN;
                    else if (wdog_expired) state_d = ST_FAULT;
                end
                CR_GREEN: begin
                    if (!car_s || hold_ok) state_d = CR_YELLOW;
                    else if (wdog_expired) state_d = ST_FAULT;
                end
                CR_YELLOW: begin
                    if (yel_ok)            state_d = HW_GREEN;
                    else if (wdog_expired) state_d = ST_FAULT;
                end
                ST_FAULT: begin
                    state_d = ST_FAULT;
                end
                default: begin
                    state_d = ST_FAULT;
                end
            endcase
        end
    end

    // Output, watchdog and blink values for the state being entered next
    always_comb begin
        entering   = (state_d != state_q);
        start_d    = arm_q || (entering && (state_d != ST_FAULT));
        fault_d    = (state_d == ST_FAULT);
        wdog_d     = '0;
        blink_d    = '0;
        blink_on_d = 1'b1;
        hw_d       = L_RED;
        cr_d       = L_RED;

        if (!entering && is_bounded(state_q)) begin
            wdog_d = (wdog_q == WDOG_SAT) ? wdog_q : wdog_q + 1'b1;
        end

        if (!entering && (state_q == ST_FAULT)) begin
            blink_d    = (blink_q == BLINK_LAST) ? '0 : blink_q + 1'b1;
            blink_on_d = (blink_q == BLINK_LAST) ? !blink_on_q : blink_on_q;
        end

        case (state_d)
            HW_GREEN:  hw_d = L_GRN;
            HW_YELLOW: hw_d = L_YEL;
            CR_GREEN:  cr_d = L_GRN;
            CR_YELLOW: cr_d = L_YEL;
            default: begin
                hw_d = blink_on_d ? L_YEL : L_RED;
                cr_d = blink_on_d ? L_YEL : L_RED;
            end
        endcase
    end

    assign START_TIMER = start_q;
    assign HW_LIGHT    = hw_q;
    assign CR_LIGHT    = cr_q;
    assign FAULT       = fault_q;

endmodule

`default_nettype wire
